// File: rtl/dmem_mmio.sv
// Data-memory stage for the pipelined MIPS core.
// Word-addressed data RAM plus a small MMIO window: GPIO output register,
// free-running cycle counter, and a byte TX FIFO drained over valid/ready.
// Loads are combinational from the current address and pre-edge state.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic        MemWriteM,
  output logic [31:0] DmmRD,
  output logic [31:0] gpio_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Word addresses (ALUOutM[31:2]) of the MMIO registers.
  localparam logic [29:0] A_GPIO   = 30'h3FFF_C000;
  localparam logic [29:0] A_CYCLE  = 30'h3FFF_C001;
  localparam logic [29:0] A_TXDATA = 30'h3FFF_C002;
  localparam logic [29:0] A_STATUS = 30'h3FFF_C003;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [31:0]   r_ram [RAM_WORDS];
  logic [31:0]   r_gpio;
  logic [31:0]   r_cycle;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_is_ram;
  logic          w_is_gpio;
  logic          w_is_cycle;
  logic          w_is_tx;
  logic          w_is_status;
  logic [AW-1:0] w_ram_idx;
  logic          w_pop;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_ovf_set;
  logic [7:0]    w_count8;
  logic [31:0]   w_status;

  assign w_is_ram    = (ALUOutM[31:28] == 4'h0);
  assign w_is_gpio   = (ALUOutM[31:2] == A_GPIO);
  assign w_is_cycle  = (ALUOutM[31:2] == A_CYCLE);
  assign w_is_tx     = (ALUOutM[31:2] == A_TXDATA);
  assign w_is_status = (ALUOutM[31:2] == A_STATUS);
  assign w_ram_idx   = ALUOutM[AW+1:2];

  // Drain handshake: tx_valid means the FIFO holds at least one byte and
  // tx_data is its head; a byte transfers on any rising edge where
  // tx_valid && tx_ready. While tx_valid=1 and tx_ready=0 the head is held.
  assign tx_valid = (r_count != '0);
  assign tx_data  = r_fifo[r_rd_ptr];
  assign gpio_out = r_gpio;

  assign w_pop      = tx_valid & tx_ready;
  assign w_push_req = MemWriteM & w_is_tx;
  // A full FIFO still accepts a push when a pop frees a slot at the same edge.
  assign w_push_ok  = w_push_req & ((r_count != DEPTH_C) | w_pop);
  assign w_ovf_set  = w_push_req & ~w_push_ok;

  // Zero-extend the occupancy into the 8-bit STATUS count field.
  always_comb begin
    w_count8           = '0;
    w_count8[CW-1:0]   = r_count;
  end

  assign w_status = {16'h0000, w_count8, 5'b00000, r_ovf,
                     (r_count == DEPTH_C), (r_count == '0)};

  // Combinational load mux; unmapped addresses read as zero.
  always_comb begin
    DmmRD = 32'h0000_0000;
    if (w_is_ram)         DmmRD = r_ram[w_ram_idx];
    else if (w_is_gpio)   DmmRD = r_gpio;
    else if (w_is_cycle)  DmmRD = r_cycle;
    else if (w_is_status) DmmRD = w_status;
  end

  // Data RAM store; not cleared by reset and written even during reset.
  always_ff @(posedge clk) begin
    if (MemWriteM && w_is_ram) r_ram[w_ram_idx] <= WriteDataM;
  end

  // GPIO output register.
  always_ff @(posedge clk) begin
    if (reset)                       r_gpio <= 32'h0000_0000;
    else if (MemWriteM && w_is_gpio) r_gpio <= WriteDataM;
  end

  // Free-running cycle counter; any CYCLE store reloads zero at that edge.
  always_ff @(posedge clk) begin
    if (reset)                        r_cycle <= 32'h0000_0000;
    else if (MemWriteM && w_is_cycle) r_cycle <= 32'h0000_0000;
    else                              r_cycle <= r_cycle + 32'd1;
  end

  // FIFO storage write; contents are not reset, only the pointers/count.
  always_ff @(posedge clk) begin
    if (!reset && w_push_ok) r_fifo[r_wr_ptr] <= WriteDataM[7:0];
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set)
        r_ovf <= 1'b1;
      else if (MemWriteM && w_is_status && WriteDataM[2])
        r_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios then randomized traffic, all
// checked against a behavioural model (RAM array, register values and a
// byte queue for the TX FIFO).
module tb_dmem_mmio;

  localparam int RAM_WORDS = 64;
  localparam int FD        = 4;

  localparam logic [31:0] GPIO_A   = 32'hFFFF_0000;
  localparam logic [31:0] CYCLE_A  = 32'hFFFF_0004;
  localparam logic [31:0] TX_A     = 32'hFFFF_0008;
  localparam logic [31:0] STATUS_A = 32'hFFFF_000C;
  localparam logic [31:0] NOMAP_A  = 32'hFFFF_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] ALUOutM = '0;
  logic [31:0] WriteDataM = '0;
  logic        MemWriteM = 1'b0;
  logic [31:0] DmmRD;
  logic [31:0] gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  dmem_mmio #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .MemWriteM  (MemWriteM),
    .DmmRD      (DmmRD),
    .gpio_out   (gpio_out),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ram [RAM_WORDS];
  bit          m_init [RAM_WORDS];
  logic [31:0] m_gpio = '0;
  logic [31:0] m_cnt  = '0;
  logic [7:0]  m_q[$];
  bit          m_ovf = 1'b0;
  bit          checking = 1'b0;
  bit          rdy_level = 1'b0;

  function automatic int ram_index(input logic [31:0] a);
    return int'((a >> 2) % 32'(RAM_WORDS));
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'(m_q.size()) << 8;
    if (m_q.size() == 0)  s = s | 32'h1;
    if (m_q.size() == FD) s = s | 32'h2;
    if (m_ovf)            s = s | 32'h4;
    return s;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (a < 32'h1000_0000) return m_ram[ram_index(a)];
    case (w)
      GPIO_A:   return m_gpio;
      CYCLE_A:  return m_cnt;
      STATUS_A: return model_status();
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input bit rst, input bit we, input logic [31:0] a,
                            input logic [31:0] wd, input bit rdy);
    logic [31:0] w;
    bit pop, set;
    int sz;
    w   = a & 32'hFFFF_FFFC;
    sz  = m_q.size();
    pop = (sz != 0) && rdy;
    set = 1'b0;
    if (we && a < 32'h1000_0000) begin
      m_ram[ram_index(a)]  = wd;
      m_init[ram_index(a)] = 1'b1;
    end
    if (rst) begin
      m_gpio = '0;
      m_cnt  = '0;
      m_q.delete();
      m_ovf  = 1'b0;
    end else begin
      m_cnt = (we && w == CYCLE_A) ? 32'h0 : m_cnt + 32'd1;
      if (we && w == GPIO_A) m_gpio = wd;
      if (pop) void'(m_q.pop_front());
      if (we && w == TX_A) begin
        if (sz < FD || pop) m_q.push_back(wd[7:0]);
        else                set = 1'b1;
      end
      if (set) m_ovf = 1'b1;
      else if (we && w == STATUS_A && wd[2]) m_ovf = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle: drive, compare pre-edge outputs with the model, clock,
  // advance the model. Returns the load data seen before the edge.
  task automatic cyc(input bit rst, input bit we, input logic [31:0] a,
                     input logic [31:0] wd, input bit rdy, output logic [31:0] rd);
    reset      = rst;
    MemWriteM  = we;
    ALUOutM    = a;
    WriteDataM = wd;
    tx_ready   = rdy;
    #2;
    rd = DmmRD;
    if (checking) begin
      if (a >= 32'h1000_0000 || m_init[ram_index(a)])
        check32("dmmrd", DmmRD, model_read(a));
      check32("gpio", gpio_out, m_gpio);
      check32("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) check32("tx_data", 32'(tx_data), 32'(m_q[0]));
    end
    @(posedge clk);
    model_edge(rst, we, a, wd, rdy);
    #1;
    if (rst) checking = 1'b1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
    cyc(1'b0, 1'b1, a, wd, rdy_level, rd);
  endtask

  task automatic ld(input logic [31:0] a, output logic [31:0] rd);
    cyc(1'b0, 1'b0, a, 32'h0, rdy_level, rd);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] t;
    t = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return {4'h0, t[27:0]};
      4, 5:       return GPIO_A + {28'h0, 2'($urandom_range(0, 3)), t[1:0]};
      6:          return TX_A + {30'h0, t[1:0]};
      7:          return STATUS_A + {30'h0, t[1:0]};
      8:          return 32'hFFFF_0010 + {24'h0, t[7:2], 2'b00};
      default:    return t;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] r;
  logic [7:0]  exp_q[$];

  initial begin
    cyc(1'b1, 1'b0, NOMAP_A, 32'h0, 1'b0, r);
    cyc(1'b1, 1'b0, NOMAP_A, 32'h0, 1'b0, r);
    check32("rst_gpio", gpio_out, 32'h0);
    check32("rst_tx_valid", 32'(tx_valid), 32'h0);

    // Counter counts cycles since reset.
    for (int i = 0; i < 10; i++) ld(NOMAP_A, r);
    ld(CYCLE_A, r);
    check32("cycle_10", r, 32'd11 - 32'd1);
    ld(STATUS_A, r);
    check32("rst_status", r, 32'h0000_0001);

    // Fill RAM so every load can be predicted.
    for (int i = 0; i < RAM_WORDS; i++) st(32'(i * 4), $urandom, r);

    // RAM store/load, read-during-write and aliasing.
    st(32'h10, 32'h1111_1111, r);
    st(32'h10, 32'hDEAD_BEEF, r);
    check32("ram_rdw_old", r, 32'h1111_1111);
    ld(32'h10, r);
    check32("ram_rd", r, 32'hDEAD_BEEF);
    ld(32'h12, r);
    check32("ram_rd_low_bits", r, 32'hDEAD_BEEF);
    ld(32'h10 + 32'(RAM_WORDS * 4), r);
    check32("ram_alias", r, 32'hDEAD_BEEF);

    // GPIO and unmapped decode.
    st(GPIO_A, 32'h0000_A5A5, r);
    check32("gpio_out", gpio_out, 32'h0000_A5A5);
    ld(GPIO_A, r);
    check32("gpio_rd", r, 32'h0000_A5A5);
    st(NOMAP_A, 32'h1234_5678, r);
    check32("nomap_gpio", gpio_out, 32'h0000_A5A5);
    ld(NOMAP_A, r);
    check32("nomap_rd", r, 32'h0);

    // Counter clear and wrap.
    st(CYCLE_A, 32'h99, r);
    ld(CYCLE_A, r);
    check32("cycle_clr", r, 32'h0);
    force dut.r_cycle = 32'hFFFF_FFFF;
    #1;
    release dut.r_cycle;
    m_cnt = 32'hFFFF_FFFF;
    ld(CYCLE_A, r);
    check32("cycle_max", r, 32'hFFFF_FFFF);
    ld(CYCLE_A, r);
    check32("cycle_wrap", r, 32'h0);

    // FIFO fill, overflow, drain.
    rdy_level = 1'b0;
    for (int i = 0; i < 4; i++) st(TX_A, 32'h41 + 32'(i), r);
    ld(STATUS_A, r);
    check32("status_full", r, 32'h0000_0402);
    st(TX_A, 32'h45, r);
    ld(STATUS_A, r);
    check32("status_ovf", r, 32'h0000_0406);
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    rdy_level = 1'b1;
    while (exp_q.size() != 0) begin
      check32("drain_valid", 32'(tx_valid), 32'h1);
      check32("drain_data", 32'(tx_data), 32'(exp_q.pop_front()));
      ld(NOMAP_A, r);
    end
    rdy_level = 1'b0;
    check32("drain_empty", 32'(tx_valid), 32'h0);
    ld(STATUS_A, r);
    check32("status_drained", r, 32'h0000_0005);
    st(STATUS_A, 32'h4, r);
    ld(STATUS_A, r);
    check32("status_ovf_clr", r, 32'h0000_0001);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) st(TX_A, 32'h61 + 32'(i), r);
    rdy_level = 1'b1;
    st(TX_A, 32'h55, r);
    rdy_level = 1'b0;
    ld(STATUS_A, r);
    check32("pushpop_status", r, 32'h0000_0402);
    exp_q = '{8'h62, 8'h63, 8'h64, 8'h55};
    rdy_level = 1'b1;
    while (exp_q.size() != 0) begin
      check32("pushpop_data", 32'(tx_data), 32'(exp_q.pop_front()));
      ld(NOMAP_A, r);
    end
    rdy_level = 1'b0;

    // Reset mid-operation; the store in the reset cycle still reaches RAM.
    for (int i = 0; i < 3; i++) st(TX_A, 32'h71 + 32'(i), r);
    st(GPIO_A, 32'h1234, r);
    cyc(1'b1, 1'b1, 32'h20, 32'hCAFE_F00D, 1'b0, r);
    check32("midrst_tx_valid", 32'(tx_valid), 32'h0);
    check32("midrst_gpio", gpio_out, 32'h0);
    ld(CYCLE_A, r);
    check32("midrst_cycle", r, 32'h0);
    ld(32'h10, r);
    check32("midrst_ram10", r, 32'hDEAD_BEEF);
    ld(32'h20, r);
    check32("midrst_ram20", r, 32'hCAFE_F00D);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1, rand_addr(),
          $urandom, $urandom_range(0, 2) == 0, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
